// File: rtl/inst_rom_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM between the
// fetch port (0) and a secondary reader (1); one-cycle tagged response.
module inst_rom_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic              flush0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rerr_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_inst_i
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e             last_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rerr_q;

    logic              elig0;
    logic              elig1;
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] gnt_addr;
    logic              misaligned;

    // A request raised during a flush cycle belongs to the old path; ignore it.
    assign elig0 = req0_i & ~flush0_i;
    assign elig1 = req1_i;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        gnt_addr = '0;
        if (rst) begin
            if (elig0 && (!elig1 || last_q == PORT1)) begin
                gnt0 = 1'b1;
            end else if (elig1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            gnt_addr = addr0_i;
        end else if (gnt1) begin
            gnt_addr = addr1_i;
        end
    end

    assign misaligned = (gnt_addr[1:0] != 2'b00);

    assign gnt0_o     = gnt0;
    assign gnt1_o     = gnt1;
    assign rom_addr_o = gnt_addr;
    assign rom_ce_o   = (gnt0 | gnt1) & ~misaligned;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q    <= PORT1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            if (gnt0 || gnt1) begin
                last_q  <= gnt1 ? PORT1 : PORT0;
                rdata_q <= misaligned ? '0 : rom_inst_i;
                rerr_q  <= misaligned;
            end
        end
    end

    // A branch redirect in the response cycle drops the stale fetch word.
    assign rvalid0_o = rvalid0_q & ~flush0_i;
    assign rvalid1_o = rvalid1_q;
    assign rdata_o   = rdata_q;
    assign rerr_o    = rerr_q;

endmodule
